spi_input_conditioner: RTL



---
 rtl/spi_input_conditioner.sv | 99 +++++++++
 1 files changed

// File: rtl/spi_input_conditioner.sv
// SPI pin front end: 2-FF synchronizer, per-channel debounce and edge strobes for SCLK, CS and MOSI.
// Conditioned levels and strobes change on the same clk edge; SCLK strobes only fire while selected.
module spi_input_conditioner #(
    parameter int WAIT_TIME = 3,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_pin,
    input  logic cs_pin,
    input  logic mosi_pin,
    output logic sclk_cond,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_cond,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_cond
);

    localparam int NCH  = 3;
    localparam int SCLK = 0;
    localparam int CS   = 1;
    localparam int MOSI = 2;

    // Idle levels per channel {mosi, cs, sclk}: deselected, clock low, data low.
    localparam logic [NCH-1:0]   IDLE     = 3'b010;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIME - 1);

    logic [NCH-1:0]   pins;
    logic [NCH-1:0]   sync_p0;
    logic [NCH-1:0]   sync_p1;
    logic [NCH-1:0]   cond_p2;
    logic [CNT_W-1:0] cnt_p2 [NCH];
    logic [NCH-1:0]   mismatch;
    logic [NCH-1:0]   upd;
    logic [1:0]       strobe_en;
    logic [1:0]       rise_p2;
    logic [1:0]       fall_p2;

    assign pins = {mosi_pin, cs_pin, sclk_pin};

    // Stage p0/p1: two-flop synchronizer into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= IDLE;
            sync_p1 <= IDLE;
        end else begin
            sync_p0 <= pins;
            sync_p1 <= sync_p0;
        end
    end

    always_comb begin
        mismatch = '0;
        upd      = '0;
        for (int i = 0; i < NCH; i++) begin
            mismatch[i] = (sync_p1[i] != cond_p2[i]);
            upd[i]      = mismatch[i] && (cnt_p2[i] == CNT_LAST);
        end
    end

    // SCLK edges are gated by the registered chip select seen before this update.
    assign strobe_en = {1'b1, ~cond_p2[CS]};

    // Stage p2: debounce counters, conditioned levels and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_p2 <= IDLE;
            for (int i = 0; i < NCH; i++) begin
                cnt_p2[i] <= '0;
            end
            rise_p2 <= '0;
            fall_p2 <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!mismatch[i]) begin
                    cnt_p2[i] <= '0;
                end else if (upd[i]) begin
                    cond_p2[i] <= sync_p1[i];
                    cnt_p2[i]  <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
                end
            end
            rise_p2 <= upd[1:0] & sync_p1[1:0] & strobe_en;
            fall_p2 <= upd[1:0] & ~sync_p1[1:0] & strobe_en;
        end
    end

    assign sclk_cond = cond_p2[SCLK];
    assign cs_cond   = cond_p2[CS];
    assign mosi_cond = cond_p2[MOSI];
    assign sclk_rise = rise_p2[SCLK];
    assign sclk_fall = fall_p2[SCLK];
    assign cs_rise   = rise_p2[CS];
    assign cs_fall   = fall_p2[CS];

endmodule
